ex_muldiv_unit: RTL and testbench
=================================

Name: ex_muldiv_unit

Overview:
Iterative RV32M multiply/divide unit in the Execute stage. It consumes the operands, funct3 and destination register held in the ID/EX pipeline register. It stalls the front of the pipeline while it computes. Its result is captured by the EX/MEM register in the single cycle in which done_o is asserted.

Parameters:
XLEN, 32, operand and result width; only 32 is supported.
CNT_W, 6, width of the iteration counter; must satisfy 2^CNT_W > XLEN.

Ports:
clk  input  1  pipeline clock; all state changes on the rising edge.
rst  input  1  asynchronous, active-low reset.
start_i  input  1  an M-extension instruction is valid in EX (MulDivE and not flushed).
funct3_i  input  3  operation: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
a_i  input  XLEN  rs1 value after forwarding.
b_i  input  XLEN  rs2 value after forwarding.
rd_i  input  5  destination register.
flush_i  input  1  abort the current operation (FlushE from the hazard unit).
stall_o  output  1  to the hazard unit; holds PC, IF/ID and ID/EX while high.
done_o  output  1  one-cycle pulse; result_o and rd_o are valid.
result_o  output  XLEN  operation result.
rd_o  output  5  destination register latched at start.

Behaviour:
- FSM states: IDLE, BUSY, DONE.
- Reset (rst low, asynchronous): state=IDLE, counter=0, all internal registers 0, result_o=0, rd_o=0, done_o=0. Reset mid-operation discards the operation with no done_o.
- stall_o (combinational) = (IDLE and start_i and not flush_i) or BUSY. It is low in DONE so the pipeline advances in that cycle.
- IDLE, start_i=1, flush_i=0 at edge E0:
  - latch funct3, rd, |a|, |b| and the result sign. Signedness: MULH and DIV/REM sign both operands; MULHSU signs a only; MUL's low word is sign-independent.
  - Quotient sign = sign(a) xor sign(b); remainder sign = sign(a).
  - Fast path, goes IDLE->DONE at E0:
    - divide by zero: DIV/DIVU result = 0xFFFFFFFF; REM/REMU result = a_i.
    - DIV 0x80000000 / 0xFFFFFFFF: result 0x80000000. REM of the same operands: result 0.
  - Otherwise go to BUSY with counter=0.
- BUSY: one iteration per cycle.
  - Multiply: shift-add over a 64-bit unsigned accumulator.
  - Divide: restoring, one quotient bit per cycle, with the remainder in a 33-bit register.
  - On the edge where counter reaches XLEN-1, apply the sign correction (two's-complement negate if needed), select the result and go to DONE.
  - Latency: done_o in cycle E32+1, i.e. stall_o is high for 33 cycles including the start cycle.
- Result word selection: MUL = low 32 bits; MULH/MULHSU/MULHU = high 32 bits of the signed-corrected 64-bit product; DIV/DIVU = quotient; REM/REMU = remainder.
- DONE:
  - done_o=1 for exactly one cycle; result_o and rd_o are stable.
  - Next edge goes to IDLE. start_i is ignored in DONE because the same instruction is still in EX.
  - result_o and rd_o hold their values until the next DONE; done_o=0 elsewhere.
- flush_i:
  - In BUSY: next edge goes to IDLE with no done_o; stall_o drops in the cycle after the flush edge.
  - In IDLE with start_i: flush wins; no start and stall_o=0.
  - In DONE: done_o still pulses; the hazard unit handles the squash.
- start_i while BUSY is ignored; the operands latched at start are used throughout, even if a_i/b_i change.
- All arithmetic is unsigned on magnitudes with a final negate. There is no X-propagation from unused funct3 paths.

Decomposition:
- Shared package riscv_pkg: funct3 constants (F3_MUL..F3_REMU), muldiv_state_t enum {IDLE,BUSY,DONE}, XLEN constant.
- Natural sub-module: md_div_core, the iterative restoring divider (load, step, quotient/remainder out). The multiplier loop and the FSM stay in ex_muldiv_unit.

Test Plan:
- MUL a=7, b=0xFFFFFFFD: start at cycle 0 -> stall_o high cycles 0..32, done_o at cycle 33, result_o=0xFFFFFFEB, rd_o=start rd.
- MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE. MULH on the same operands -> 0x00000000. MULHSU 0xFFFFFFFF,0x00000002 -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD and REM -> 0xFFFFFFFF. DIVU 100/7 -> 14 and REMU -> 2, each done at cycle 33.
- DIVU 5/0 -> done_o in cycle 1 with 0xFFFFFFFF. REM 5/0 -> 5. DIV 0x80000000/0xFFFFFFFF -> 0x80000000 in cycle 1. stall_o high only in cycle 0 in all three cases.
- DIV started with flush_i high at cycle 10 -> no done_o, stall_o=0 from cycle 11. A new MUL started at cycle 12 -> correct result at cycle 45.
- rst pulled low at cycle 5 of a DIV -> immediately IDLE with all outputs 0. After release, start is accepted and a fresh DIV is correct.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32M definitions: funct3 encodings, mul/div FSM states, conditional negate.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } muldiv_state_t;

    // Two's-complement negate when neg is set; used to move between magnitude and signed form.
    function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/md_div_core.sv
// Iterative unsigned restoring divider, one quotient bit per step.
// Latency: XLEN steps after load; quo_nxt/rem_nxt show the value after the current step.
// Backpressure: none; advances only when step is high, holds otherwise.
module md_div_core #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            step,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] quo_nxt,
    output logic [XLEN-1:0] rem_nxt
);

    logic [XLEN-1:0] quo_q;
    logic [XLEN:0]   rem_q;
    logic [XLEN-1:0] dvsr_q;

    logic [XLEN+1:0] shifted;
    logic [XLEN+1:0] diff;
    logic [XLEN:0]   rem_w;

    // Trial subtraction: shift the next dividend bit into the partial remainder and
    // keep the difference only if it did not go negative.
    always_comb begin
        shifted = {rem_q, quo_q[XLEN-1]};
        diff    = shifted - {2'b00, dvsr_q};
        if (!diff[XLEN+1]) begin
            rem_w   = diff[XLEN:0];
            quo_nxt = {quo_q[XLEN-2:0], 1'b1};
        end else begin
            rem_w   = shifted[XLEN:0];
            quo_nxt = {quo_q[XLEN-2:0], 1'b0};
        end
        rem_nxt = rem_w[XLEN-1:0];
    end

    // Divider state: the quotient register starts as the dividend and fills from the LSB.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            quo_q  <= '0;
            rem_q  <= '0;
            dvsr_q <= '0;
        end else if (load) begin
            quo_q  <= dividend;
            rem_q  <= '0;
            dvsr_q <= divisor;
        end else if (step) begin
            quo_q  <= quo_nxt;
            rem_q  <= rem_w;
        end
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// RV32M multiply/divide unit in EX: iterative shift-add multiply, restoring divide.
// Latency: 33 cycles start-to-done (1 cycle for divide-by-zero and signed overflow).
// Backpressure: stall_o holds the front of the pipe while busy; result valid for one done_o cycle.
module ex_muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic [4:0]      rd_i,
    input  logic            flush_i,
    output logic            stall_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      rd_o
);

    import riscv_pkg::*;

    muldiv_state_t state_q, state_d;

    logic [CNT_W-1:0]  cnt_q;
    logic [2:0]        f3_q;
    logic [4:0]        rd_q;
    logic              neg_q;
    logic              rneg_q;
    logic [XLEN-1:0]   mcand_q;
    logic [2*XLEN-1:0] acc_q;
    logic [XLEN-1:0]   result_q;
    logic [4:0]        rd_out_q;

    logic              start_go;
    logic              last;
    logic              sa, sb;
    logic [XLEN-1:0]   ma, mb;
    logic              fast;
    logic [XLEN-1:0]   fast_res;
    logic [XLEN:0]     psum;
    logic [2*XLEN-1:0] acc_nxt;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   q_nxt, r_nxt;
    logic [XLEN-1:0]   final_res;

    assign start_go = (state_q == IDLE) && start_i && !flush_i;
    assign last     = (cnt_q == CNT_W'(XLEN - 1));
    assign result_o = result_q;
    assign rd_o     = rd_out_q;

    // Operand decode at start: operand signs, magnitudes and the single-cycle special cases.
    always_comb begin
        sa = a_i[XLEN-1] && ((funct3_i == F3_MULH) || (funct3_i == F3_MULHSU) ||
                             (funct3_i == F3_DIV)  || (funct3_i == F3_REM));
        sb = b_i[XLEN-1] && ((funct3_i == F3_MULH) || (funct3_i == F3_DIV) ||
                             (funct3_i == F3_REM));
        ma = cond_neg(a_i, sa);
        mb = cond_neg(b_i, sb);
        fast = funct3_i[2] && ((b_i == '0) ||
               (!funct3_i[0] && (a_i == {1'b1, {(XLEN-1){1'b0}}}) && (b_i == '1)));
        if (b_i == '0) begin
            fast_res = funct3_i[1] ? a_i : '1;
        end else begin
            // Signed overflow: quotient is the dividend itself, remainder is zero.
            fast_res = funct3_i[1] ? '0 : a_i;
        end
    end

    // One multiply iteration on the accumulator: add the multiplicand into the high half
    // when the current multiplier bit is set, then shift the whole thing right.
    always_comb begin
        psum     = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
        acc_nxt  = {psum, acc_q[XLEN-1:1]};
        prod_fix = neg_q ? (~acc_nxt + 1'b1) : acc_nxt;
        if (f3_q[2]) begin
            final_res = f3_q[1] ? cond_neg(r_nxt, rneg_q) : cond_neg(q_nxt, neg_q);
        end else begin
            final_res = (f3_q == F3_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
        end
    end

    md_div_core #(.XLEN(XLEN)) u_div (
        .clk      (clk),
        .rst      (rst),
        .load     (start_go),
        .step     ((state_q == BUSY) && !flush_i),
        .dividend (ma),
        .divisor  (mb),
        .quo_nxt  (q_nxt),
        .rem_nxt  (r_nxt)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and handshake outputs; stall drops in DONE so the pipe advances with the result.
    always_comb begin
        state_d = state_q;
        stall_o = 1'b0;
        done_o  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_go) begin
                    stall_o = 1'b1;
                    state_d = fast ? DONE : BUSY;
                end
            end
            BUSY: begin
                stall_o = 1'b1;
                if (flush_i) begin
                    state_d = IDLE;
                end else if (last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath: latch the operation at start, iterate while busy, commit the result on the last step.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q    <= '0;
            f3_q     <= '0;
            rd_q     <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            mcand_q  <= '0;
            acc_q    <= '0;
            result_q <= '0;
            rd_out_q <= '0;
        end else if (start_go) begin
            cnt_q   <= '0;
            f3_q    <= funct3_i;
            rd_q    <= rd_i;
            neg_q   <= sa ^ sb;
            rneg_q  <= sa;
            mcand_q <= mb;
            acc_q   <= {{XLEN{1'b0}}, ma};
            if (fast) begin
                result_q <= fast_res;
                rd_out_q <= rd_i;
            end
        end else if (state_q == BUSY) begin
            if (flush_i) begin
                cnt_q <= '0;
            end else begin
                acc_q <= acc_nxt;
                cnt_q <= last ? '0 : cnt_q + 1'b1;
                if (last) begin
                    result_q <= final_res;
                    rd_out_q <= rd_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Bench for ex_muldiv_unit: directed RV32M cases plus random operations against an arithmetic model.
// Latency: checks 33-cycle iterative and 1-cycle special-case completion.
// Backpressure: checks stall_o over the whole operation, flush and reset aborts.
module tb_ex_muldiv_unit;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic [2:0]  funct3_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic [4:0]  rd_i;
    logic        flush_i;
    logic        stall_o;
    logic        done_o;
    logic [31:0] result_o;
    logic [4:0]  rd_o;

    int n_cmp;
    int n_err;

    ex_muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (
        .clk      (clk),
        .rst      (rst),
        .start_i  (start_i),
        .funct3_i (funct3_i),
        .a_i      (a_i),
        .b_i      (b_i),
        .rd_i     (rd_i),
        .flush_i  (flush_i),
        .stall_o  (stall_o),
        .done_o   (done_o),
        .result_o (result_o),
        .rd_o     (rd_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // RV32M semantics straight from the ISA rules, using wide native arithmetic.
    function automatic logic [31:0] ref_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint      sa_l, sb_l, ub_l;
        logic [63:0] p;
        int          si_a, si_b;
        logic [31:0] r;
        sa_l = longint'($signed(a));
        sb_l = longint'($signed(b));
        ub_l = longint'({32'h0, b});
        si_a = $signed(a);
        si_b = $signed(b);
        r = 32'h0;
        case (f3)
            3'd0: begin p = {32'h0, a} * {32'h0, b}; r = p[31:0]; end
            3'd1: begin p = sa_l * sb_l;             r = p[63:32]; end
            3'd2: begin p = sa_l * ub_l;             r = p[63:32]; end
            3'd3: begin p = {32'h0, a} * {32'h0, b}; r = p[63:32]; end
            3'd4: begin
                if (b == 0) r = 32'hFFFFFFFF;
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 32'h80000000;
                else r = si_a / si_b;
            end
            3'd5: r = (b == 0) ? 32'hFFFFFFFF : a / b;
            3'd6: begin
                if (b == 0) r = a;
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 32'h0;
                else r = si_a % si_b;
            end
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (f3[2] && b == 0) return 1;
        if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
        return 33;
    endfunction

    function automatic logic [31:0] rand_operand();
        logic [31:0] v;
        case ($urandom_range(0, 6))
            0: v = 32'h0;
            1: v = 32'h80000000;
            2: v = 32'hFFFFFFFF;
            3: v = $urandom_range(0, 15);
            4: v = -$urandom_range(1, 15);
            default: v = $urandom;
        endcase
        return v;
    endfunction

    // Issue one operation, scramble the inputs while it runs, and check timing and result.
    task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        logic [31:0] exp;
        int          exp_lat;
        int          lat;
        exp     = ref_op(f3, a, b);
        exp_lat = ref_lat(f3, a, b);
        @(negedge clk);
        start_i = 1'b1; funct3_i = f3; a_i = a; b_i = b; rd_i = rd; flush_i = 1'b0;
        #1;
        chk("stall_start", 32'(stall_o), 32'd1);
        lat = 0;
        while (1) begin
            @(negedge clk);
            lat++;
            start_i  = 1'($urandom_range(0, 1));
            funct3_i = 3'($urandom);
            a_i      = $urandom;
            b_i      = $urandom;
            rd_i     = 5'($urandom);
            #1;
            if (done_o || lat >= 40) break;
            chk("stall_busy", 32'(stall_o), 32'd1);
        end
        chk("done_seen", 32'(done_o), 32'd1);
        chk("latency", lat, exp_lat);
        chk("result", result_o, exp);
        chk("rd", 32'(rd_o), 32'(rd));
        chk("stall_done", 32'(stall_o), 32'd0);
        @(negedge clk);
        start_i = 1'b0;
        #1;
        chk("done_pulse", 32'(done_o), 32'd0);
        chk("result_hold", result_o, exp);
        chk("stall_idle", 32'(stall_o), 32'd0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b0; start_i = 1'b0; funct3_i = 3'd0; a_i = '0; b_i = '0; rd_i = '0; flush_i = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_stall", 32'(stall_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_result", result_o, 32'd0);
        chk("rst_rd", 32'(rd_o), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Directed cases
        do_op(3'd0, 32'd7, 32'hFFFFFFFD, 5'd3);
        chk("mul_neg_literal", result_o, 32'hFFFFFFEB);
        do_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4);
        do_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5);
        do_op(3'd2, 32'hFFFFFFFF, 32'h00000002, 5'd6);
        do_op(3'd4, -32'sd7, 32'd2, 5'd7);
        do_op(3'd6, -32'sd7, 32'd2, 5'd8);
        do_op(3'd5, 32'd100, 32'd7, 5'd9);
        do_op(3'd7, 32'd100, 32'd7, 5'd10);
        do_op(3'd5, 32'd5, 32'd0, 5'd11);
        do_op(3'd6, 32'd5, 32'd0, 5'd12);
        do_op(3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd13);
        do_op(3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd14);

        // Flush mid-operation: DIV from cycle 0, flush at cycle 10, new MUL at cycle 12
        @(negedge clk);
        start_i = 1'b1; funct3_i = 3'd4; a_i = 32'd1000; b_i = 32'd3; rd_i = 5'd15;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            start_i = 1'b0;
            flush_i = (c == 10);
            #1;
            chk("flush_busy_stall", 32'(stall_o), 32'd1);
            chk("flush_busy_done", 32'(done_o), 32'd0);
        end
        @(negedge clk);
        flush_i = 1'b0;
        #1;
        chk("flush_stall_drop", 32'(stall_o), 32'd0);
        chk("flush_no_done", 32'(done_o), 32'd0);
        do_op(3'd0, 32'h12345678, 32'h9ABCDEF0, 5'd16);

        // Flush in IDLE beats start
        @(negedge clk);
        start_i = 1'b1; flush_i = 1'b1; funct3_i = 3'd5; a_i = 32'd9; b_i = 32'd0; rd_i = 5'd17;
        #1;
        chk("idle_flush_stall", 32'(stall_o), 32'd0);
        @(negedge clk);
        start_i = 1'b0; flush_i = 1'b0;
        #1;
        chk("idle_flush_done", 32'(done_o), 32'd0);
        chk("idle_flush_rd", 32'(rd_o), 32'd16);

        // Flush while DONE still pulses done_o
        @(negedge clk);
        start_i = 1'b1; funct3_i = 3'd7; a_i = 32'd21; b_i = 32'd0; rd_i = 5'd18;
        @(negedge clk);
        start_i = 1'b0; flush_i = 1'b1;
        #1;
        chk("done_flush_pulse", 32'(done_o), 32'd1);
        chk("done_flush_result", result_o, 32'd21);
        @(negedge clk);
        flush_i = 1'b0;

        // Asynchronous reset at cycle 5 of a DIV
        @(negedge clk);
        start_i = 1'b1; funct3_i = 3'd4; a_i = 32'd77; b_i = 32'd5; rd_i = 5'd19;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            start_i = 1'b0;
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_stall", 32'(stall_o), 32'd0);
        chk("midrst_done", 32'(done_o), 32'd0);
        chk("midrst_result", result_o, 32'd0);
        chk("midrst_rd", 32'(rd_o), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 35; c++) begin
            @(negedge clk);
            #1;
            chk("midrst_quiet", 32'(done_o), 32'd0);
        end
        do_op(3'd4, -32'sd100, 32'd9, 5'd20);

        // Random operations
        for (int i = 0; i < 80; i++) begin
            logic [31:0] ra, rb;
            ra = rand_operand();
            rb = rand_operand();
            do_op(3'($urandom_range(0, 7)), ra, rb, 5'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
